// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine: one op at a time via valid/ready,
// one shift-add / shift-subtract step per clock, result held until taken.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q;
  logic              sign_a_q, sign_b_q, special_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   b_q, hi_q, lo_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept;
  logic              sign_a_in, sign_b_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special_in;
  logic [XLEN-1:0]   special_val;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // ---------------------------------------------------------------- accept decode
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sign_a_in = 1'b0;
    sign_b_in = 1'b0;
    unique case (op_t'(op))
      OP_MULH, OP_DIV, OP_REM: begin
        sign_a_in = rs1[XLEN-1];
        sign_b_in = rs2[XLEN-1];
      end
      OP_MULHSU: sign_a_in = rs1[XLEN-1];
      default: ;
    endcase
  end

  assign mag_a = sign_a_in ? -rs1 : rs1;
  assign mag_b = sign_b_in ? -rs2 : rs2;

  // Division corner cases are resolved up front and skip the iteration entirely.
  assign div_zero   = op[2] && (rs2 == '0);
  assign div_ovf    = op[2] && !op[0] && (rs1 == MIN_INT) && (rs2 == '1);
  assign special_in = div_zero || div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)     special_val = op[1] ? rs1 : '1;
    else if (div_ovf) special_val = op[1] ? '0 : MIN_INT;
  end

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special_in ? FIX : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // ---------------------------------------------------------------- one iteration
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_nx, lo_nx;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[2]) begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_nx = div_diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_nx = div_shift[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------- sign fixup
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix  = sign_a_q ? -hi_q : hi_q;
    fix_val  = '0;
    if (special_q) begin
      fix_val = lo_q;
    end else begin
      unique case (op_q)
        OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              fix_val = quo_fix;
        OP_REM, OP_REMU:              fix_val = rem_fix;
        default:                      fix_val = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath registers
  // NOTE: sequential state uses non-blocking assignments only; the operand registers are
  // reset too so a partially computed op can never leak into result after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MUL;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      tag_q     <= '0;
      result    <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      op_q      <= op_t'(op);
      sign_a_q  <= sign_a_in;
      sign_b_q  <= sign_b_in;
      special_q <= special_in;
      cnt_q     <= CNT_W'(XLEN - 1);
      b_q       <= mag_b;
      hi_q      <= '0;
      lo_q      <= special_in ? special_val : mag_a;
      tag_q     <= rd_tag;
    end else if (state_q == CALC && !flush) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (state_q == FIX && !flush) begin
      result  <= fix_val;
      out_tag <= tag_q;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// hold/flush/reset sequences, and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1(rs1), .rs2(rs2), .rd_tag(rd_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    longint      q;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Latency counts the accept edge as edge 1; out_valid is sampled after each edge.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    op = o; rs1 = a; rs2 = b; rd_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_tag = 5'($urandom);
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " tag"}, out_tag, tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, " idle after take"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int vcount;
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,       34};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,        34};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         2};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2};
    vecs[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[13] = '{3'd7, 32'd5,         32'd0,         32'd5,         2};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {out_valid, busy, result, out_tag}, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);

    // Directed table
    foreach (vecs[i])
      run_op($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
             5'(i + 1), vecs[i].exp, vecs[i].lat);

    // Hold result in DONE with out_ready low; an offered op must not be accepted
    @(negedge clk);
    op = 3'd0; rs1 = 32'h7; rs2 = 32'hFFFF_FFFD; rd_tag = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 100 && !out_valid; c++) @(negedge clk);
    check("hold reached done", out_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      op = 3'd5; rs1 = 32'd1; rs2 = 32'd1; rd_tag = 5'd30; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold cyc%0d", c), {out_valid, in_ready, busy, result, out_tag},
            {1'b1, 1'b0, 1'b1, 32'hFFFF_FFEB, 5'd9});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold release idle", {out_valid, busy, in_ready}, 3'b001);

    // Flush mid-CALC, with a simultaneous offer that must be refused
    @(negedge clk);
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; rd_tag = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flush pre busy", busy, 1'b1);
    flush = 1'b1; op = 3'd4; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1;
    #1 check("flush blocks in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush to idle", {busy, out_valid}, 2'b00);
    vcount = 0;
    repeat (40) begin @(negedge clk); if (out_valid) vcount++; end
    check("flush no out_valid", vcount, 0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush idle no accept", busy, 1'b0);

    // Async reset mid-CALC clears outputs immediately
    @(negedge clk);
    op = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rd_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset mid calc", {out_valid, busy, result, out_tag}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    vcount = 0;
    repeat (40) begin @(negedge clk); if (out_valid) vcount++; end
    check("reset no partial", vcount, 0);
    run_op("after reset", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 34);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d op%0d a=%0h b=%0h", i, o, a, b), o, a, b, 5'($urandom),
             ref_model(o, a, b), ref_latency(o, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
